// File: rtl/fifo_frame_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_frame_rd_ctrl_if
// Bundles the two data-carrying sides of the frame read controller:
//   FIFO read port : fifo_rd_level, fifo_empty, fifo_rd_data (into controller),
//                    fifo_rd_en (out of controller)
//   Frame stream   : m_data, m_valid, m_sop, m_eop (out of controller),
//                    m_ready (into controller)
// Modports:
//   master - the frame read controller
//   slave  - the FIFO plus the downstream consumer
//
// Stream handshake: a beat transfers on every rising clock edge where
// m_valid and m_ready are both high. Once m_valid is raised, m_data, m_sop
// and m_eop stay unchanged until the beat transfers; m_ready may change in
// any cycle and never depends combinationally on m_valid being low.
// m_sop and m_eop carry meaning only while m_valid is high.
// -----------------------------------------------------------------------------
interface fifo_frame_rd_ctrl_if #(
    parameter int DATA_W  = 31,
    parameter int LEVEL_W = 10
);
    logic [LEVEL_W-1:0] fifo_rd_level;
    logic               fifo_empty;
    logic               fifo_rd_en;
    logic [DATA_W-1:0]  fifo_rd_data;

    logic [DATA_W-1:0]  m_data;
    logic               m_valid;
    logic               m_sop;
    logic               m_eop;
    logic               m_ready;

    modport master (
        input  fifo_rd_level,
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid,
        output m_sop,
        output m_eop
    );

    modport slave (
        output fifo_rd_level,
        output fifo_empty,
        output fifo_rd_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid,
        input  m_sop,
        input  m_eop
    );
endinterface

// File: rtl/fifo_frame_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_frame_rd_ctrl
// Read-side scheduler for the audio sample FIFO. Waits until the FIFO holds
// START_LEVEL words, then reads exactly FRAME_LEN words and presents them as
// one framed burst (sop on the first beat, eop on the last) to the FFT/FIR
// datapath. The FIFO has a 1-cycle read latency; returning words land in a
// 2-entry output buffer so downstream backpressure never loses data.
//
// Ports:
//   sys_clk, sys_rstn : clock, asynchronous active-low reset
//   enable            : run request, sampled in IDLE and at frame end
//   bus (master)      : FIFO read port and frame stream, see fifo_frame_rd_ctrl_if
//   busy              : high in WAIT_LVL, BURST and DRAIN
//   frame_cnt         : completed frames, wraps at 16 bits
//   underrun_err      : sticky, FIFO was empty while a frame read was owed
//   state_dbg         : current FSM state (IDLE=0, WAIT_LVL=1, BURST=2, DRAIN=3)
//   snap_level        : only with FRAME_LEVEL_SNAP_EN defined; FIFO level
//                       captured when each frame starts
//
// Optional feature macro: FRAME_LEVEL_SNAP_EN
// -----------------------------------------------------------------------------
module fifo_frame_rd_ctrl #(
    parameter int DATA_W      = 31,
    parameter int LEVEL_W     = 10,
    parameter int FRAME_LEN   = 256,
    parameter int START_LEVEL = 256
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 enable,
    fifo_frame_rd_ctrl_if.master bus,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic                 underrun_err,
    output logic [1:0]           state_dbg
`ifdef FRAME_LEVEL_SNAP_EN
    ,
    output logic [LEVEL_W-1:0]   snap_level
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LVL = 2'd1,
        BURST    = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [LEVEL_W-1:0] rd_left;
    logic [LEVEL_W-1:0] out_cnt;
    logic               inflight;

    logic [DATA_W-1:0]  buf_mem [2];
    logic               head_ptr;
    logic               tail_ptr;
    logic [1:0]         buf_occ;

    logic               valid;
    logic               pop;
    logic               eop_beat;
    logic               eop_hs;
    logic               level_ok;
    logic               frame_start;
    logic [2:0]         credit_sum;
    logic               credit_ok;
    logic               read_owed;
    logic               rd_en;

    // ------------------------------------------------------------------
    // Combinational datapath control
    // ------------------------------------------------------------------
    assign valid    = (buf_occ != 2'd0);
    assign pop      = valid & bus.m_ready;
    assign eop_beat = (out_cnt == LEVEL_W'(FRAME_LEN - 1));
    assign eop_hs   = pop & eop_beat;
    assign level_ok = (bus.fifo_rd_level >= LEVEL_W'(START_LEVEL));

    // Words already held plus the word still returning from the FIFO, less
    // the beat leaving this cycle, must leave room for one more word.
    // pop implies buf_occ >= 1, so the subtraction cannot wrap.
    assign credit_sum = {1'b0, buf_occ} + {2'b00, inflight} - {2'b00, pop};
    assign credit_ok  = (credit_sum < 3'd2);

    assign read_owed = (state_q == BURST) && (rd_left != '0) && credit_ok;
    assign rd_en     = read_owed && !bus.fifo_empty;

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf_mem[head_ptr];
    assign bus.m_sop      = valid & (out_cnt == '0);
    assign bus.m_eop      = valid & eop_beat;

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT_LVL;
                end
            end
            WAIT_LVL: begin
                if (level_ok) begin
                    state_d     = BURST;
                    frame_start = 1'b1;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                // The frame is committed once started; enable is ignored
                // until the eop beat has been accepted.
                if (rd_en && (rd_left == LEVEL_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (eop_hs) begin
                    state_d = enable ? WAIT_LVL : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read accounting, output buffer, framing counters
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rd_left      <= '0;
            inflight     <= 1'b0;
            buf_mem[0]   <= '0;
            buf_mem[1]   <= '0;
            head_ptr     <= 1'b0;
            tail_ptr     <= 1'b0;
            buf_occ      <= 2'd0;
            out_cnt      <= '0;
            frame_cnt    <= 16'd0;
            underrun_err <= 1'b0;
        end else begin
            if (frame_start) begin
                rd_left <= LEVEL_W'(FRAME_LEN);
            end else if (rd_en) begin
                rd_left <= rd_left - LEVEL_W'(1);
            end

            // fifo_rd_data is valid exactly one cycle after the strobe.
            inflight <= rd_en;

            if (inflight) begin
                buf_mem[tail_ptr] <= bus.fifo_rd_data;
                tail_ptr          <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            buf_occ <= buf_occ + {1'b0, inflight} - {1'b0, pop};

            if (eop_hs) begin
                out_cnt   <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (pop) begin
                out_cnt <= out_cnt + LEVEL_W'(1);
            end

            if (read_owed && bus.fifo_empty) begin
                underrun_err <= 1'b1;
            end
        end
    end

`ifdef FRAME_LEVEL_SNAP_EN
    // Slack monitor: how full the FIFO was when each frame was launched.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            snap_level <= '0;
        end else if (frame_start) begin
            snap_level <= bus.fifo_rd_level;
        end
    end
`endif

endmodule
